// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : enc_pkg
// Purpose : Shared constants and types for the 8-to-3 sequential encoder.
//           N_DEF  - default number of request lines
//           CW_DEF - default code width ($clog2(N_DEF))
//           state_t - output-stage control state (EMPTY / HOLD)
// Revision: 1.0 - initial release
// ============================================================================
package enc_pkg;

  localparam int N_DEF  = 8;
  localparam int CW_DEF = 3;

  // EMPTY: no code presented; HOLD: out_code is valid and waiting for acceptance
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage : enc_pkg
`default_nettype wire

// File: rtl/enc_pick.sv
`default_nettype none
// ============================================================================
// Module  : enc_pick
// Purpose : Combinational rotating first-set-bit picker.
//           Rotates cand right by base, finds the lowest set bit of the rotated
//           vector, then adds base back (mod N). With base=0 this is a plain
//           lowest-index priority encoder.
// Ports   : cand [N]  in  - candidate request set
//           base [CW] in  - search start index
//           idx  [CW] out - chosen index (only meaningful when any=1)
//           any       out - cand has at least one bit set
// Revision: 1.0 - initial release
// ============================================================================
module enc_pick
  import enc_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int CW = $clog2(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [CW-1:0] base,
  output logic [CW-1:0] idx,
  output logic          any
);

  logic [N-1:0]  w_rot;
  logic [CW-1:0] w_src;
  logic [CW-1:0] w_off;

  always_comb begin
    w_rot = '0;
    w_src = '0;
    w_off = '0;
    // Rotated bit i comes from original position (i + base); CW-bit add wraps
    // modulo N because N is a power of two.
    for (int i = 0; i < N; i++) begin
      w_src    = CW'(i) + base;
      w_rot[i] = cand[w_src];
    end
    // Descending scan so the lowest set bit wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = CW'(i);
      end
    end
    any = |cand;
    idx = w_off + base;
  end

endmodule : enc_pick
`default_nettype wire

// File: rtl/encoder_8to3_seq.sv
`default_nettype none
// ============================================================================
// Module  : encoder_8to3_seq
// Purpose : Registered N-to-log2(N) request encoder with valid/ready output.
//           Requests are collected into a sticky pending set; one index is
//           issued per accepted transfer and its bit cleared as it is served.
// Ports   : clk        in      - rising-edge clock
//           rst_n      in      - asynchronous active-low reset
//           EN         in      - capture enable for req
//           req        in  N   - request lines, bit i requests code i
//           out_ready  in      - consumer accepts out_code this cycle
//           out_valid  out     - out_code is valid
//           out_code   out CW  - encoded index of the served request
//           pending    out N   - captured requests not yet issued
// Config  : ENC_ROUND_ROBIN_EN - when defined, search starts at a rotating
//           pointer (one past the last issued index) instead of bit 0.
// Revision: 1.0 - initial release
// ============================================================================
module encoder_8to3_seq
  import enc_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          EN,
  input  logic [N-1:0]  req,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [CW-1:0] out_code,
  output logic [N-1:0]  pending
);

  localparam logic [N-1:0] c_one = N'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_pending;
  logic [CW-1:0] r_code;

  logic [N-1:0]  w_cand;
  logic          w_load;
  logic          w_any;
  logic [CW-1:0] w_idx;
  logic [CW-1:0] w_base;

  assign w_cand = r_pending | (EN ? req : '0);
  // The output register may be refilled when empty or being drained this cycle.
  assign w_load = (r_state == ST_EMPTY) || out_ready;

  enc_pick #(
    .N (N)
  ) u_pick (
    .cand (w_cand),
    .base (w_base),
    .idx  (w_idx),
    .any  (w_any)
  );

`ifdef ENC_ROUND_ROBIN_EN
  logic [CW-1:0] r_rr_ptr;

  // Pointer moves one past every issued index; CW-bit add wraps N-1 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_load && w_any) begin
      r_rr_ptr <= w_idx + CW'(1);
    end
  end

  assign w_base = r_rr_ptr;
`else
  assign w_base = '0;
`endif

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_any) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready && !w_any) begin
          w_state_nxt = ST_EMPTY;
        end
      end
    endcase
  end

  // Data path: pending set and output code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_code    <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_code    <= w_idx;
        // A request arriving on the bit being issued is absorbed by this issue.
        r_pending <= w_cand & ~(c_one << w_idx);
      end else begin
        r_pending <= '0;
      end
    end else begin
      // Stall: output holds, new requests keep accumulating.
      r_pending <= w_cand;
    end
  end

  assign out_valid = (r_state == ST_HOLD);
  assign out_code  = r_code;
  assign pending   = r_pending;

endmodule : encoder_8to3_seq
`default_nettype wire

// File: tb/tb_encoder_8to3_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_encoder_8to3_seq
// Purpose : Self-checking bench for encoder_8to3_seq. A behavioural model of
//           the pending set predicts each issued code and pushes it into a
//           queue; a monitor pops and compares on every accepted transfer.
//           Directed cases cover reset, single/multi-hot, stall, EN gating
//           and steady requests; a randomized phase follows.
// Config  : ENC_ROUND_ROBIN_EN - selects the round-robin model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_encoder_8to3_seq;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] req = '0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] out_code;
  logic [7:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0] m_pend  = '0;
  logic       m_valid = 1'b0;
  int         m_code  = 0;
  int         m_ptr   = 0;
  int         exp_q[$];

  encoder_8to3_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EN        (EN),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_code  (out_code),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // First requested index in search order starting at the model pointer.
  function automatic int model_pick(input logic [7:0] cand, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (cand[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic en, input logic [7:0] r, input logic rdy);
    logic [7:0] cand;
    int idx;
    cand = m_pend | (en ? r : 8'h00);
    if (!m_valid || rdy) begin
      if (cand != 0) begin
`ifdef ENC_ROUND_ROBIN_EN
        idx = model_pick(cand, m_ptr);
`else
        idx = model_pick(cand, 0);
`endif
        m_code  = idx;
        m_valid = 1'b1;
        cand[idx] = 1'b0;
        m_pend  = cand;
        m_ptr   = (idx + 1) % N;
        exp_q.push_back(idx);
      end else begin
        m_valid = 1'b0;
        m_pend  = 8'h00;
      end
    end else begin
      m_pend = cand;
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_valid = 1'b0; m_code = 0; m_ptr = 0;
    exp_q.delete();
  endtask

  // Drive inputs, advance one edge, update the model, settle.
  task automatic step(input logic en, input logic [7:0] r, input logic rdy);
    EN = en; req = r; out_ready = rdy;
    @(posedge clk);
    model_edge(en, r, rdy);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, "_pending"}, 32'(pending), 32'(m_pend));
  endtask

  // Scoreboard monitor: compares on every accepted transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk("sb_code", 32'(out_code), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    @(posedge clk); #1;
    chk("por_valid", 32'(out_valid), 0);
    chk("por_code", 32'(out_code), 0);
    chk("por_pending", 32'(pending), 0);
    rst_n = 1'b1;

    // Single request
    step(1'b1, 8'h20, 1'b1);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_code", 32'(out_code), 5);
    step(1'b0, 8'h00, 1'b1);
    chk("single_empty", 32'(out_valid), 0);

    // Multi-hot, lowest index first
    step(1'b1, 8'h8A, 1'b1);
    chk("multi_code0", 32'(out_code), 1);
    chk("multi_pend0", 32'(pending), 32'h88);
    step(1'b0, 8'h00, 1'b1);
    chk("multi_code1", 32'(out_code), 3);
    chk("multi_pend1", 32'(pending), 32'h80);
    step(1'b0, 8'h00, 1'b1);
    chk("multi_code2", 32'(out_code), 7);
    chk("multi_pend2", 32'(pending), 32'h00);
    step(1'b0, 8'h00, 1'b1);
    chk("multi_empty", 32'(out_valid), 0);

    // Stall with accumulation
    step(1'b1, 8'h02, 1'b1);
    chk("stall_code_a", 32'(out_code), 1);
    step(1'b1, 8'h04, 1'b0);
    chk("stall_hold_valid", 32'(out_valid), 1);
    chk("stall_hold_code", 32'(out_code), 1);
    chk("stall_pend", 32'(pending), 32'h04);
    step(1'b0, 8'h00, 1'b1);
    chk("stall_code_b", 32'(out_code), 2);
    step(1'b0, 8'h00, 1'b1);
    chk("stall_empty", 32'(out_valid), 0);

    // Asynchronous reset between edges with state in flight
    step(1'b1, 8'h0C, 1'b0);
    chk_model("prerst");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_code", 32'(out_code), 0);
    chk("arst_pending", 32'(pending), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // EN gating
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'hFF, 1'b1);
      chk("engate_valid", 32'(out_valid), 0);
      chk("engate_pend", 32'(pending), 0);
    end
    step(1'b1, 8'hFF, 1'b1);
    chk("en_code0", 32'(out_code), 0);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 8'hFF, 1'b1);
      chk("en_code_seq", 32'(out_code), 32'(i));
    end
    step(1'b0, 8'h00, 1'b1);
    chk("en_empty", 32'(out_valid), 0);

    // Steady request on two lines
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h81, 1'b1);
`ifdef ENC_ROUND_ROBIN_EN
      chk("steady_code", 32'(out_code), (i % 2 == 1) ? 32'd7 : 32'd0);
`else
      chk("steady_code", 32'(out_code), 32'd0);
`endif
      chk_model("steady");
    end
    for (int i = 0; i < 20 && (m_valid || m_pend != 0); i++) step(1'b0, 8'h00, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      step(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 9) < 7));
      chk_model("rand");
    end

    // Drain
    for (int i = 0; i < 20 && (m_valid || m_pend != 0); i++) step(1'b0, 8'h00, 1'b1);
    @(negedge clk); #1;
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_queue", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_encoder_8to3_seq
`default_nettype wire
